// File: rtl/ece555_pkg.sv
// Shared definitions for the ECE555 XOR-sharing arbiter: state encoding,
// default sizes and the one-hot / round-robin helpers used by the top.
package ece555_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_NREQ  = 8;

  function automatic logic [MAX_NREQ-1:0] onehotFromIdx(input logic [2:0] idx);
    logic [MAX_NREQ-1:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  // Lowest offset from ptr wins, so scan offsets high-to-low and let later hits overwrite.
  function automatic logic [2:0] rrPick(input logic [MAX_NREQ-1:0] req,
                                        input logic [2:0] ptr,
                                        input int nreq);
    logic [2:0] pick;
    int slot;
    pick = ptr;
    for (int off = MAX_NREQ - 1; off >= 0; off--) begin
      if (off < nreq) begin
        slot = (int'(ptr) + off) % nreq;
        if (req[slot[2:0]]) pick = slot[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xor_share_arb_cell.sv
// The shared XOR library cell; purely combinational, one bit wide.
module xor_share_arb_cell (
  output logic OUT,
  input  logic A,
  input  logic B
);

  assign OUT = A ^ B;

endmodule

// File: rtl/xor_share_arb.sv
// Round-robin arbiter that grants one requester at a time and streams its
// operands LSB-first through the single shared XOR cell.
module xor_share_arb
  import ece555_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = $clog2(WIDTH),
  parameter int PW    = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] A_IN,
  input  logic [NREQ*WIDTH-1:0] B_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [WIDTH-1:0]      RESULT,
  output logic                  BUSY
);

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;

  logic [2:0]       w_pickIdx;
  logic [PW-1:0]    w_nextPtr;
  logic [WIDTH-1:0] w_pickA;
  logic [WIDTH-1:0] w_pickB;
  logic             w_aBit;
  logic             w_bBit;
  logic             w_xorBit;

  assign w_pickIdx = rrPick(8'(REQ), 3'(r_ptr), NREQ);
  assign w_nextPtr = (int'(w_pickIdx) == NREQ - 1) ? '0 : PW'(w_pickIdx + 3'd1);
  assign w_pickA   = A_IN[int'(w_pickIdx)*WIDTH +: WIDTH];
  assign w_pickB   = B_IN[int'(w_pickIdx)*WIDTH +: WIDTH];

  assign w_aBit = r_opA[r_count];
  assign w_bBit = r_opB[r_count];

  xor_share_arb_cell U_XOR (
    .OUT (w_xorBit),
    .A   (w_aBit),
    .B   (w_bBit)
  );

  // Sequencer: grant, WIDTH serial shifts, one FIN cycle carrying DONE, then a forced IDLE cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      GNT     <= '0;
      DONE    <= '0;
      RESULT  <= '0;
      BUSY    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|REQ) begin
            GNT     <= NREQ'(onehotFromIdx(w_pickIdx));
            r_opA   <= w_pickA;
            r_opB   <= w_pickB;
            r_count <= '0;
            r_ptr   <= w_nextPtr;
            BUSY    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          RESULT  <= {w_xorBit, RESULT[WIDTH-1:1]};
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            DONE    <= GNT;
            r_state <= FIN;
          end
        end
        FIN: begin
          DONE    <= '0;
          GNT     <= '0;
          BUSY    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arb.sv
// Self-checking bench for xor_share_arb: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_xor_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] A_IN = '0;
  logic [N*W-1:0] B_IN = '0;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [W-1:0]   RESULT;
  logic           BUSY;

  int totalChecks = 0;
  int badChecks = 0;

  always #5 CLK = ~CLK;

  xor_share_arb #(.NREQ(N), .WIDTH(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .A_IN   (A_IN),
    .B_IN   (B_IN),
    .GNT    (GNT),
    .DONE   (DONE),
    .RESULT (RESULT),
    .BUSY   (BUSY)
  );

  // Reference model: tracks one operation as (owner, word, elapsed cycles) and the last completed word.
  bit           mActive = 1'b0;
  int           mOwner = 0;
  int           mPtr = 0;
  int           mCyc = 0;
  int           pickJ;
  logic [W-1:0] mX = '0;
  logic [W-1:0] mOld = '0;
  logic [W-1:0] mHold = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mActive = 1'b0;
      mPtr    = 0;
      mCyc    = 0;
      mHold   = '0;
    end else if (!mActive) begin
      if (REQ != '0) begin
        mOwner = -1;
        for (int k = 0; k < N; k++) begin
          pickJ = (mPtr + k) % N;
          if (mOwner < 0 && REQ[pickJ]) mOwner = pickJ;
        end
        mX      = A_IN[mOwner*W +: W] ^ B_IN[mOwner*W +: W];
        mOld    = mHold;
        mPtr    = (mOwner + 1) % N;
        mCyc    = 0;
        mActive = 1'b1;
      end
    end else if (mCyc == W) begin
      mActive = 1'b0;
      mHold   = mX;
    end else begin
      mCyc++;
    end
  end

  function automatic logic [N-1:0] modelDone();
    logic [N-1:0] d;
    d = '0;
    if (mActive && mCyc == W) d[mOwner] = 1'b1;
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [N-1:0]   eG;
    logic [2*W-1:0] cat;
    logic [W-1:0]   eR;
    eG = '0;
    eR = mHold;
    if (mActive) begin
      eG[mOwner] = 1'b1;
      cat = {mX, mOld};
      cat = cat >> mCyc;
      eR  = cat[W-1:0];
    end
    checkOutput("gnt", GNT, eG);
    checkOutput("done", DONE, modelDone());
    checkOutput("result", RESULT, eR);
    checkOutput("busy", BUSY, mActive);
    checkOutput("gntOnehot", ($countones(GNT) <= 1), 1);
    checkOutput("doneOnehot", ($countones(DONE) <= 1), 1);
    checkOutput("doneUnderGnt", ((DONE & ~GNT) == '0), 1);
    checkOutput("busyEqGnt", BUSY, |GNT);
  endtask

  task automatic stepCycle();
    @(negedge CLK);
    checkModel();
  endtask

  task automatic resetDut();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    REQ = '0;
    repeat (2) @(negedge CLK);
    checkOutput("rstGnt", GNT, 0);
    checkOutput("rstDone", DONE, 0);
    checkOutput("rstResult", RESULT, 0);
    checkOutput("rstBusy", BUSY, 0);
    RST_N = 1'b1;
  endtask

  // One directed operation: grant next edge, optional operand change / REQ drop, DONE after W cycles.
  task automatic runOp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expRes, input int dropAt);
    bit seen;
    A_IN[idx*W +: W] = a;
    B_IN[idx*W +: W] = b;
    REQ[idx] = 1'b1;
    seen = 1'b0;
    for (int waited = 0; waited < 40 && !seen; waited++) begin
      stepCycle();
      if (waited == 0) checkOutput("opGrant", GNT, 32'd1 << idx);
      if (waited == dropAt) begin
        A_IN[idx*W +: W] = '0;
        REQ[idx] = 1'b0;
      end
      if (DONE[idx]) begin
        seen = 1'b1;
        checkOutput("opResult", RESULT, expRes);
        checkOutput("opLatency", waited, W);
        REQ[idx] = 1'b0;
      end
    end
    checkOutput("opDoneSeen", seen, 1);
    stepCycle();
    checkOutput("opIdleBusy", BUSY, 0);
  endtask

  task automatic applyStimulus();
    logic [N-1:0] doneM;
    int r;
    stepCycle();
    doneM = modelDone();
    for (int i = 0; i < N; i++) begin
      if (doneM[i]) begin
        REQ[i] = 1'b0;
      end else if (!REQ[i] && $urandom_range(0, 3) == 0) begin
        REQ[i] = 1'b1;
        A_IN[i*W +: W] = W'($urandom);
        B_IN[i*W +: W] = W'($urandom);
      end
    end
    if ($urandom_range(0, 15) == 0) begin
      r = int'($urandom_range(0, N - 1));
      A_IN[r*W +: W] = W'($urandom);
    end
    if (mActive && mCyc < W && $urandom_range(0, 31) == 0) REQ[mOwner] = 1'b0;
  endtask

  initial begin
    logic [N-1:0] gOrder [5];
    logic [W-1:0] rOrder [5];
    logic [N-1:0] prevG;
    int nGr;
    int nDn;
    bit granted;

    gOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rOrder = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};

    $display("[TB] start");
    resetDut();
    stepCycle();

    runOp(0, 8'hA5, 8'h3C, 8'h99, -1);

    resetDut();
    for (int i = 0; i < N; i++) begin
      A_IN[i*W +: W] = W'(i);
      B_IN[i*W +: W] = 8'hFF;
    end
    REQ = '1;
    prevG = '0;
    nGr = 0;
    nDn = 0;
    for (int c = 0; c < 52; c++) begin
      stepCycle();
      if (GNT != '0 && prevG == '0 && nGr < 5) begin
        checkOutput("rrOrder", GNT, gOrder[nGr]);
        nGr++;
      end
      if (DONE != '0 && nDn < 5) begin
        checkOutput("rrResult", RESULT, rOrder[nDn]);
        nDn++;
      end
      prevG = GNT;
    end
    checkOutput("rrGrantCount", nGr, 5);
    checkOutput("rrDoneCount", nDn, 5);
    REQ = '0;
    repeat (12) stepCycle();

    resetDut();
    A_IN[0*W +: W] = 8'h77;
    B_IN[0*W +: W] = 8'h11;
    REQ = 4'b0001;
    granted = 1'b0;
    for (int c = 0; c < 5 && !granted; c++) begin
      stepCycle();
      if (GNT != '0) granted = 1'b1;
    end
    checkOutput("midGranted", granted, 1);
    repeat (3) stepCycle();
    #2 RST_N = 1'b0;
    REQ = '0;
    #1;
    checkOutput("asyncGnt", GNT, 0);
    checkOutput("asyncDone", DONE, 0);
    checkOutput("asyncResult", RESULT, 0);
    checkOutput("asyncBusy", BUSY, 0);
    repeat (2) stepCycle();
    RST_N = 1'b1;
    runOp(2, 8'h12, 8'h34, 8'h26, -1);

    runOp(1, 8'hF0, 8'h0F, 8'hFF, 2);
    runOp(3, 8'h5A, 8'h5A, 8'h00, -1);
    runOp(0, 8'hFF, 8'h00, 8'hFF, -1);

    for (int c = 0; c < 1500; c++) applyStimulus();
    REQ = '0;
    repeat (15) stepCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
